ifsram_w: RTL and testbench

//  Input-feature SRAM write stage; sits upstream of the ifsram read/window stage.

---
 rtl/ifsram_w.sv | 119 +++++++++++
 tb/tb_ifsram_w.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifsram_w.sv
// ifsram_w: streams feature words into a 3-slot ifsram row ring, row by row
module ifsram_w #(
   parameter int TBITS  = 64,
   parameter int TBYTE  = 8,
   parameter int COL    = 15,
   parameter int CH     = 4,
   parameter int ADDR_W = 11
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_write_start,
   input  logic [1:0]        row_cnt,
   input  logic [1:0]        slot_base,
   output logic              if_write_busy,
   output logic              if_write_done,
   output logic              row_finish,
   input  logic [TBITS-1:0]  isif_data,
   input  logic              isif_valid,
   output logic              isif_ready,
   output logic              cen_writes_ifsram,
   output logic              wen_writes_ifsram,
   output logic [ADDR_W-1:0] addr_write_ifsram,
   output logic [TBITS-1:0]  data_write_ifsram
);
   localparam int STRIDE = (COL + 1) * CH;
   localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
   localparam int COL_W  = (COL > 1) ? $clog2(COL) : 1;

   if (TBITS != TBYTE * 8) begin : g_width_check
      $error("ifsram_w: TBITS must equal TBYTE*8");
   end

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [1:0]        r_rows, r_base, r_row;
   logic [CH_W-1:0]   r_ch;
   logic [COL_W-1:0]  r_col;
   logic              w_acc, w_last_ch, w_last_col, w_last_row;
   logic [2:0]        w_sum;
   logic [1:0]        w_slot;
   logic [ADDR_W-1:0] w_addr;

   assign w_acc      = isif_valid && (r_state == S_WRITE);
   assign w_last_ch  = (r_ch == CH_W'(CH - 1));
   assign w_last_col = (r_col == COL_W'(COL - 1));
   assign w_last_row = (r_row == r_rows - 2'd1);
   assign w_sum      = {1'b0, r_base} + {1'b0, r_row};
   assign w_slot     = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
   assign w_addr     = ADDR_W'(w_slot * STRIDE + r_col * CH + r_ch);

   // state register
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next state and handshake outputs
   always_comb begin
      w_next        = r_state;
      isif_ready    = 1'b0;
      if_write_busy = 1'b0;
      if_write_done = 1'b0;
      case (r_state)
         S_IDLE:  if (if_write_start) w_next = (row_cnt == 2'd0) ? S_DONE : S_WRITE;
         S_WRITE: begin
            isif_ready    = 1'b1;
            if_write_busy = 1'b1;
            if (w_acc && w_last_ch && w_last_col && w_last_row) w_next = S_DONE;
         end
         S_DONE: begin
            if_write_busy = 1'b1;
            if_write_done = 1'b1;
            w_next        = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // job latch and ch/col/row position counters, advancing only on accepted beats
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rows <= '0;
         r_base <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_ch   <= '0;
      end else if (r_state == S_IDLE && if_write_start) begin
         r_rows <= row_cnt;
         r_base <= (slot_base == 2'd3) ? 2'd0 : slot_base;
         r_row  <= '0;
         r_col  <= '0;
         r_ch   <= '0;
      end else if (w_acc) begin
         r_ch  <= w_last_ch ? '0 : r_ch + 1'b1;
         r_col <= w_last_ch ? (w_last_col ? '0 : r_col + 1'b1) : r_col;
         r_row <= (w_last_ch && w_last_col) ? (w_last_row ? 2'd0 : r_row + 2'd1) : r_row;
      end
   end

   // registered SRAM write one cycle after acceptance; addr/data hold otherwise
   always_ff @(posedge clk) begin
      if (!reset) begin
         cen_writes_ifsram <= 1'b1;
         wen_writes_ifsram <= 1'b1;
         addr_write_ifsram <= '0;
         data_write_ifsram <= '0;
         row_finish        <= 1'b0;
      end else begin
         cen_writes_ifsram <= !w_acc;
         wen_writes_ifsram <= !w_acc;
         row_finish        <= w_acc && w_last_ch && w_last_col;
         if (w_acc) begin
            addr_write_ifsram <= w_addr;
            data_write_ifsram <= isif_data;
         end
      end
   end
endmodule

// File: tb/tb_ifsram_w.sv
// tb_ifsram_w: randomized stream jobs against a queue-based model of the ring layout
module tb_ifsram_w;
   localparam int TBITS  = 64;
   localparam int COL    = 15;
   localparam int CH     = 4;
   localparam int ADDR_W = 11;
   localparam int ROW    = COL * CH;
   localparam int STRIDE = (COL + 1) * CH;

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [TBITS-1:0]  d;
      logic              rf;
      logic              last;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              if_write_start = 1'b0;
   logic [1:0]        row_cnt = 2'd0;
   logic [1:0]        slot_base = 2'd0;
   logic              if_write_busy, if_write_done, row_finish;
   logic [TBITS-1:0]  isif_data = '0;
   logic              isif_valid = 1'b0;
   logic              isif_ready;
   logic              cen_writes_ifsram, wen_writes_ifsram;
   logic [ADDR_W-1:0] addr_write_ifsram;
   logic [TBITS-1:0]  data_write_ifsram;

   wr_t               exp_q[$];
   logic [TBITS-1:0]  beats[$];
   int                n_checks = 0;
   int                n_fail = 0;
   bit                mon_on = 1'b0;

   ifsram_w dut (
      .clk(clk), .reset(reset), .if_write_start(if_write_start), .row_cnt(row_cnt),
      .slot_base(slot_base), .if_write_busy(if_write_busy), .if_write_done(if_write_done),
      .row_finish(row_finish), .isif_data(isif_data), .isif_valid(isif_valid),
      .isif_ready(isif_ready), .cen_writes_ifsram(cen_writes_ifsram),
      .wen_writes_ifsram(wen_writes_ifsram), .addr_write_ifsram(addr_write_ifsram),
      .data_write_ifsram(data_write_ifsram)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // every SRAM write must be the next one the model expects, in order
   always @(negedge clk) begin : monitor
      wr_t e;
      if (mon_on) begin
         if (!cen_writes_ifsram) begin
            if (exp_q.size() == 0) check("spurious_write", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               check("wen", 64'(wen_writes_ifsram), 64'd0);
               check("addr", 64'(addr_write_ifsram), 64'(e.a));
               check("data", data_write_ifsram, e.d);
               check("row_finish", 64'(row_finish), 64'(e.rf));
               check("done", 64'(if_write_done), 64'(e.last));
               check("busy_write", 64'(if_write_busy), 64'd1);
            end
         end else begin
            check("wen_idle", 64'(wen_writes_ifsram), 64'd1);
            check("row_finish_idle", 64'(row_finish), 64'd0);
            check("done_idle", 64'(if_write_done), 64'd0);
         end
      end
   end

   task automatic build(input int rows, input int base, input bit incr);
      int  b = (base == 3) ? 0 : base;
      wr_t e;
      exp_q.delete();
      beats.delete();
      for (int k = 0; k < rows * ROW; k++) begin
         e.a    = ADDR_W'(((b + k / ROW) % 3) * STRIDE + k % ROW);
         e.d    = incr ? 64'(k) : {$urandom, $urandom};
         e.rf   = (k % ROW == ROW - 1);
         e.last = (k == rows * ROW - 1);
         exp_q.push_back(e);
         beats.push_back(e.d);
      end
   endtask

   task automatic start(input int rows, input int base);
      @(negedge clk);
      if_write_start = 1'b1;
      row_cnt        = 2'(rows);
      slot_base      = 2'(base);
      @(negedge clk);
      if_write_start = 1'b0;
   endtask

   task automatic send(input int first, input int n, input int mode, input int mid_cyc);
      int i = first;
      int cyc = 0;
      bit acc;
      while (i < first + n && cyc < 8 * n + 50) begin
         isif_valid     = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
         isif_data      = isif_valid ? beats[i] : {$urandom, $urandom};
         if_write_start = (cyc == mid_cyc);
         if (cyc == mid_cyc) row_cnt = 2'd3;
         acc = isif_valid && isif_ready;
         @(negedge clk);
         if (acc) i++;
         cyc++;
      end
      isif_valid     = 1'b0;
      if_write_start = 1'b0;
      if (i < first + n) check("beat_timeout", 64'(i), 64'(first + n));
   endtask

   task automatic finish_job();
      @(negedge clk);
      check("busy_after", 64'(if_write_busy), 64'd0);
      check("ready_after", 64'(isif_ready), 64'd0);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic job(input int rows, input int base, input int mode, input bit incr, input int mid_cyc);
      build(rows, base, incr);
      start(rows, base);
      send(0, rows * ROW, mode, mid_cyc);
      finish_job();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(isif_ready), 64'd0);
      check("rst_cen", 64'(cen_writes_ifsram), 64'd1);
      check("rst_wen", 64'(wen_writes_ifsram), 64'd1);
      check("rst_addr", 64'(addr_write_ifsram), 64'd0);
      check("rst_data", data_write_ifsram, 64'd0);
      check("rst_busy", 64'(if_write_busy), 64'd0);
      check("rst_done", 64'(if_write_done), 64'd0);
      check("rst_row_finish", 64'(row_finish), 64'd0);
      reset  = 1'b1;
      mon_on = 1'b1;
      job(1, 0, 0, 1'b1, -1);
      job(3, 2, 0, 1'b0, -1);
      job(2, 3, 1, 1'b0, -1);
      job(2, 0, 2, 1'b0, 40);
      build(2, 0, 1'b0);
      start(2, 0);
      send(0, 30, 2, -1);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready", 64'(isif_ready), 64'd0);
      check("abort_cen", 64'(cen_writes_ifsram), 64'd1);
      check("abort_done", 64'(if_write_done), 64'd0);
      check("abort_busy", 64'(if_write_busy), 64'd0);
      check("abort_pending", 64'(exp_q.size()), 64'(2 * ROW - 30));
      exp_q.delete();
      reset = 1'b1;
      job(1, 1, 0, 1'b0, -1);
      mon_on = 1'b0;
      @(negedge clk);
      if_write_start = 1'b1;
      row_cnt        = 2'd0;
      slot_base      = 2'd0;
      @(negedge clk);
      if_write_start = 1'b0;
      check("empty_done", 64'(if_write_done), 64'd1);
      check("empty_busy", 64'(if_write_busy), 64'd1);
      check("empty_ready", 64'(isif_ready), 64'd0);
      check("empty_cen", 64'(cen_writes_ifsram), 64'd1);
      @(negedge clk);
      check("empty_done_end", 64'(if_write_done), 64'd0);
      check("empty_busy_end", 64'(if_write_busy), 64'd0);
      check("empty_ready_end", 64'(isif_ready), 64'd0);
      check("empty_cen_end", 64'(cen_writes_ifsram), 64'd1);
      mon_on = 1'b1;
      for (int j = 0; j < 3; j++)
         job($urandom_range(1, 3), $urandom_range(0, 3), 2, 1'b0, -1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
